// File: rtl/ysyx_pkg.sv
// Shared fetch-path definitions: FSM state encoding, AXI read response
// code and the architectural reset PC used by both the PC register and fetch.
package ysyx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] PC_RESET  = 32'h8000_0000;

    // Instructions are word sized, so the two low PC bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AXI4-Lite style read per instruction, the
// result held for decode until execute commits it.
module ifu_fetch #(
    parameter int         WIDTH     = 32,
    parameter logic [1:0] RESP_OKAY = ysyx_pkg::RESP_OKAY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc,
    input  logic             exu_valid,
    output logic [WIDTH-1:0] araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic             fetch_fault,
    output logic             misalign_fault
);
    import ysyx_pkg::fetch_state_e;
    import ysyx_pkg::IDLE;
    import ysyx_pkg::REQ;
    import ysyx_pkg::WAIT;
    import ysyx_pkg::HOLD;
    import ysyx_pkg::is_word_aligned;

    fetch_state_e state;

    // IDLE lasts one cycle after commit so that pc is sampled after the PC
    // register has advanced; every output is a flop, nothing is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            araddr         <= '0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            inst           <= '0;
            inst_valid     <= 1'b0;
            fetch_fault    <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    araddr <= pc;
                    if (is_word_aligned(pc[1:0])) begin
                        arvalid <= 1'b1;
                        state   <= REQ;
                    end else begin
                        misalign_fault <= 1'b1;
                        inst           <= '0;
                        inst_valid     <= 1'b1;
                        state          <= HOLD;
                    end
                end
                REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A faulting word is still captured; fetch_fault tells decode not to run it.
                    if (rvalid) begin
                        rready      <= 1'b0;
                        inst        <= rdata;
                        fetch_fault <= (rresp != RESP_OKAY);
                        inst_valid  <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (exu_valid) begin
                        inst_valid     <= 1'b0;
                        fetch_fault    <= 1'b0;
                        misalign_fault <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then
// randomized bus/commit traffic checked against a transaction-level model.
module tb_ifu_fetch;
    localparam int          WIDTH   = 32;
    localparam logic [31:0] PC_BASE = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  pc;
    logic              exu_valid;
    logic [WIDTH-1:0]  araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              fetch_fault;
    logic              misalign_fault;

    int vectors     = 0;
    int miscompares = 0;

    // Model of the fetch in flight: what has happened to it so far.
    bit          m_busy;
    bit          m_misaligned;
    bit          m_addr_accepted;
    bit          m_data_returned;
    bit          m_err;
    logic [31:0] m_addr;
    logic [31:0] m_inst;

    always #5 clk = ~clk;

    ifu_fetch #(.WIDTH(WIDTH), .RESP_OKAY(2'b00)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .exu_valid      (exu_valid),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .fetch_fault    (fetch_fault),
        .misalign_fault (misalign_fault)
    );

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_busy          = 1'b0;
        m_misaligned    = 1'b0;
        m_addr_accepted = 1'b0;
        m_data_returned = 1'b0;
        m_err           = 1'b0;
        m_addr          = '0;
        m_inst          = '0;
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic model_step();
        bit holding;
        holding = m_busy && (m_misaligned || m_data_returned);
        if (!m_busy) begin
            m_busy          = 1'b1;
            m_addr          = pc;
            m_misaligned    = (pc % 4) != 0;
            m_addr_accepted = 1'b0;
            m_data_returned = 1'b0;
            if (m_misaligned) m_inst = '0;
        end else if (holding) begin
            if (exu_valid) m_busy = 1'b0;
        end else if (!m_addr_accepted) begin
            if (arready) m_addr_accepted = 1'b1;
        end else if (rvalid) begin
            m_data_returned = 1'b1;
            m_inst          = rdata;
            m_err           = (rresp != 2'b00);
        end
    endtask

    task automatic check_output();
        logic exp_iv;
        exp_iv = m_busy && (m_misaligned || m_data_returned);
        check_val("araddr", araddr, m_addr);
        check_bit("arvalid", arvalid, m_busy && !m_misaligned && !m_addr_accepted);
        check_bit("rready", rready, m_busy && m_addr_accepted && !m_data_returned);
        check_bit("inst_valid", inst_valid, exp_iv);
        check_val("inst", inst, m_inst);
        check_bit("fetch_fault", fetch_fault, exp_iv && !m_misaligned && m_err);
        check_bit("misalign_fault", misalign_fault, exp_iv && m_misaligned);
    endtask

    task automatic apply_stimulus(input logic ex, input logic ar, input logic rv,
                                  input logic [31:0] rd, input logic [1:0] rr);
        exu_valid = ex;
        arready   = ar;
        rvalid    = rv;
        rdata     = rd;
        rresp     = rr;
    endtask

    // One clock edge: update the model, then compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        else       model_reset();
        check_output();
    endtask

    initial begin
        int latency;
        logic committed;

        rst_n = 1'b1;
        pc    = PC_BASE;
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0013, 2'b00);
        #1 rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        check_val("reset_araddr", araddr, 32'h0);
        check_bit("reset_inst_valid", inst_valid, 1'b0);

        // Reset release, best-case handshakes.
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check_bit("first_arvalid", arvalid, 1'b1);
        check_val("first_araddr", araddr, 32'h8000_0000);
        cycle();
        check_bit("first_rready", rready, 1'b1);
        cycle();
        check_bit("first_inst_valid", inst_valid, 1'b1);
        check_val("first_inst", inst, 32'h0000_0013);
        check_bit("first_fetch_fault", fetch_fault, 1'b0);
        check_bit("first_misalign", misalign_fault, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0000_0093, 2'b00);
        cycle();
        cycle();
        check_bit("hold_inst_valid", inst_valid, 1'b1);

        // Commit with PC advancing, then backpressure on both channels.
        exu_valid = 1'b1;
        cycle();
        exu_valid = 1'b0;
        pc        = PC_BASE + 32'd4;
        latency   = 0;
        for (int n = 1; n <= 20 && latency == 0; n++) begin
            if (n == 5) arready = 1'b1;
            if (n == 8) rvalid  = 1'b1;
            cycle();
            if (n <= 5) check_val("bp_araddr", araddr, 32'h8000_0004);
            if (inst_valid) latency = n;
        end
        check_val("bp_latency", 32'(latency), 32'd8);
        check_val("bp_inst", inst, 32'h0000_0093);

        // Bus error response.
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10);
        cycle();
        exu_valid = 1'b0;
        pc        = PC_BASE + 32'd8;
        cycle();
        cycle();
        cycle();
        check_bit("err_inst_valid", inst_valid, 1'b1);
        check_bit("err_fetch_fault", fetch_fault, 1'b1);
        check_val("err_inst", inst, 32'hDEAD_BEEF);
        exu_valid = 1'b1;
        cycle();
        exu_valid = 1'b0;
        pc        = PC_BASE + 32'd2;
        check_bit("err_cleared_fault", fetch_fault, 1'b0);
        check_bit("err_cleared_valid", inst_valid, 1'b0);

        // Misaligned PC: no bus request at all.
        rresp = 2'b00;
        cycle();
        check_bit("mis_inst_valid", inst_valid, 1'b1);
        check_bit("mis_fault", misalign_fault, 1'b1);
        check_val("mis_inst", inst, 32'h0);
        for (int n = 0; n < 3; n++) begin
            check_bit("mis_arvalid", arvalid, 1'b0);
            cycle();
        end
        exu_valid = 1'b1;
        cycle();
        exu_valid = 1'b0;
        pc        = PC_BASE + 32'd12;

        // Reset asserted between edges while waiting for read data.
        rvalid = 1'b0;
        cycle();
        cycle();
        check_bit("wait_rready", rready, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_bit("async_rready", rready, 1'b0);
        check_bit("async_arvalid", arvalid, 1'b0);
        check_bit("async_inst_valid", inst_valid, 1'b0);
        model_reset();
        check_output();
        @(negedge clk) rst_n = 1'b1;
        rvalid = 1'b1;
        cycle();
        check_bit("post_reset_arvalid", arvalid, 1'b1);
        check_val("post_reset_araddr", araddr, 32'h8000_000C);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle();
            committed = exu_valid;
            if (committed) begin
                if ($urandom_range(0, 9) == 0) pc = $urandom;
                else                           pc = pc + 32'd4;
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_output();
                @(negedge clk) rst_n = 1'b1;
            end
            exu_valid = ($urandom_range(0, 3) == 0);
            arready   = 1'($urandom_range(0, 1));
            rvalid    = 1'($urandom_range(0, 1));
            rdata     = $urandom;
            rresp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
